div_unit: RTL

- Multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
- It is the initiator of the EX stall request. While a division is in flight it holds ex_stall high, so the stall controller freezes PC/IF/ID/EX.
- When done it returns {remainder, quotient} for the HI/LO write path.

---
 rtl/div_if.sv | 44 ++++
 rtl/div_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/div_if.sv
// div_if: EX-stage <-> divider connection.
// Signals: start/signed_div/opdata1/opdata2/annul go from EX to the divider,
// and result/ready/ex_stall come back.
// Optional macro DIV_ZERO_FLAG_EN adds the div_zero flag.
//
// Handshake: EX raises start with the operands and keeps start high until it
// samples ready=1. The divider holds result/ready steady for as long as start
// stays high after completion. A cycle with start=0 returns the divider to idle.
// annul aborts a request that has not completed yet.
interface div_if #(
   parameter int DATA_W = 32
) ();
   logic                  start;
   logic                  signed_div;
   logic [DATA_W-1:0]     opdata1;
   logic [DATA_W-1:0]     opdata2;
   logic                  annul;
   logic [2*DATA_W-1:0]   result;
   logic                  ready;
   logic                  ex_stall;
`ifdef DIV_ZERO_FLAG_EN
   logic                  div_zero;

   modport master (
      output start, signed_div, opdata1, opdata2, annul,
      input  result, ready, ex_stall, div_zero
   );

   modport slave (
      input  start, signed_div, opdata1, opdata2, annul,
      output result, ready, ex_stall, div_zero
   );
`else
   modport master (
      output start, signed_div, opdata1, opdata2, annul,
      input  result, ready, ex_stall
   );

   modport slave (
      input  start, signed_div, opdata1, opdata2, annul,
      output result, ready, ex_stall
   );
`endif
endinterface

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU.
// The divider holds the EX stall request while a division is in flight.
// It returns {remainder, quotient}.
// Optional macro DIV_ZERO_FLAG_EN adds a div_zero flag, which is raised with
// ready when the divisor was zero.
// dbg_state exposes the FSM state with this encoding:
// 0=FREE, 1=BYZERO, 2=ON, 3=END.
module div_unit #(
   parameter int DATA_W = 32
) (
   input  logic        clk,
   input  logic        rst,
   div_if.slave        bus,
   output logic [1:0]  dbg_state
);

   localparam int CNT_W = $clog2(DATA_W) + 1;

   typedef enum logic [1:0] {
      S_FREE   = 2'd0,
      S_BYZERO = 2'd1,
      S_ON     = 2'd2,
      S_END    = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   // {partial remainder (W+1 bits), dividend/quotient (W bits)}
   logic [2*DATA_W:0]     dividend_q, dividend_d;
   logic [DATA_W-1:0]     divisor_q, divisor_d;
   logic                  neg_quo_q, neg_quo_d;
   logic                  neg_rem_q, neg_rem_d;
   logic [2*DATA_W-1:0]   result_q, result_d;
   logic                  ready_q, ready_d;
`ifdef DIV_ZERO_FLAG_EN
   logic                  zero_q, zero_d;
`endif

   logic [DATA_W+1:0]     shifted;
   logic [DATA_W+1:0]     diff;
   logic [2*DATA_W:0]     iter_val;
   logic [DATA_W-1:0]     quo_raw, rem_raw, quo_fix, rem_fix;
   logic [DATA_W-1:0]     abs1, abs2;

   // One restoring step: shift left, trial-subtract, keep or restore.
   // Compute the sign-corrected outputs of the step as well.
   always_comb begin
      shifted = dividend_q[2*DATA_W:DATA_W-1];
      diff    = shifted - {2'b00, divisor_q};
      if (!diff[DATA_W+1]) begin
         iter_val = {diff[DATA_W:0], dividend_q[DATA_W-2:0], 1'b1};
      end else begin
         iter_val = {shifted[DATA_W:0], dividend_q[DATA_W-2:0], 1'b0};
      end
      quo_raw = iter_val[DATA_W-1:0];
      rem_raw = iter_val[2*DATA_W-1:DATA_W];
      quo_fix = neg_quo_q ? (~quo_raw + 1'b1) : quo_raw;
      rem_fix = neg_rem_q ? (~rem_raw + 1'b1) : rem_raw;
   end

   // Take operand magnitudes for DIV. The magnitude of the most negative value
   // wraps to the same bit pattern, which is correct when treated as unsigned.
   always_comb begin
      abs1 = (bus.signed_div && bus.opdata1[DATA_W-1]) ? (~bus.opdata1 + 1'b1) : bus.opdata1;
      abs2 = (bus.signed_div && bus.opdata2[DATA_W-1]) ? (~bus.opdata2 + 1'b1) : bus.opdata2;
   end

   // Next-state logic for the FSM and all datapath registers.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      dividend_d = dividend_q;
      divisor_d  = divisor_q;
      neg_quo_d  = neg_quo_q;
      neg_rem_d  = neg_rem_q;
      result_d   = result_q;
      ready_d    = ready_q;
`ifdef DIV_ZERO_FLAG_EN
      zero_d     = zero_q;
`endif
      case (state_q)
         S_FREE: begin
            ready_d = 1'b0;
            if (bus.start && !bus.annul) begin
               if (bus.opdata2 == '0) begin
                  state_d = S_BYZERO;
               end else begin
                  state_d    = S_ON;
                  dividend_d = {{(DATA_W+1){1'b0}}, abs1};
                  divisor_d  = abs2;
                  neg_quo_d  = bus.signed_div & (bus.opdata1[DATA_W-1] ^ bus.opdata2[DATA_W-1]);
                  neg_rem_d  = bus.signed_div & bus.opdata1[DATA_W-1];
                  cnt_d      = '0;
               end
            end
         end
         S_BYZERO: begin
            if (bus.annul) begin
               state_d = S_FREE;
            end else begin
               state_d  = S_END;
               result_d = '0;
               ready_d  = 1'b1;
`ifdef DIV_ZERO_FLAG_EN
               zero_d   = 1'b1;
`endif
            end
         end
         S_ON: begin
            if (bus.annul) begin
               state_d = S_FREE;
            end else begin
               dividend_d = iter_val;
               cnt_d      = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(DATA_W - 1)) begin
                  state_d  = S_END;
                  result_d = {rem_fix, quo_fix};
                  ready_d  = 1'b1;
               end
            end
         end
         S_END: begin
            ready_d = 1'b1;
            if (!bus.start) begin
               state_d = S_FREE;
               ready_d = 1'b0;
`ifdef DIV_ZERO_FLAG_EN
               zero_d  = 1'b0;
`endif
            end
         end
         default: state_d = S_FREE;
      endcase
   end

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_FREE;
         cnt_q      <= '0;
         dividend_q <= '0;
         divisor_q  <= '0;
         neg_quo_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         result_q   <= '0;
         ready_q    <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
         zero_q     <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dividend_q <= dividend_d;
         divisor_q  <= divisor_d;
         neg_quo_q  <= neg_quo_d;
         neg_rem_q  <= neg_rem_d;
         result_q   <= result_d;
         ready_q    <= ready_d;
`ifdef DIV_ZERO_FLAG_EN
         zero_q     <= zero_d;
`endif
      end
   end

   // The stall request is combinational, so annul drops it in the same cycle.
   assign bus.ex_stall = bus.start & ~bus.annul & (state_q != S_END);
   assign bus.result   = result_q;
   assign bus.ready    = ready_q;
`ifdef DIV_ZERO_FLAG_EN
   assign bus.div_zero = zero_q;
`endif
   assign dbg_state    = state_q;

endmodule
